// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: control FSM for a radix-2 Booth multiplier datapath.
//
// One accepted start captures both signed operands. The FSM then clears the
// datapath, loads it, and runs N evaluate/shift pairs. During each evaluate
// step the datapath feedback {LQ[0], Q_1} picks add, subtract or no-op.
// done pulses for one cycle while the datapath Y output holds the 2N-bit
// product.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   start          request, honoured only in IDLE or DONE
//   A_in, B_in     signed multiplicand / multiplier, captured on start
//   Q_LSB          datapath feedback {LQ[0], Q_1}
//   op_A, op_B     captured operands driven to the datapath
//   dp_rst         datapath clear (combined with rst at the datapath)
//   mult_control   {load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub}
//   busy           high in CLEAR, LOAD, EVAL and SHIFT
//   done           one-cycle pulse, product valid on Y
module booth_mult_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A_in,
  input  logic [N-1:0] B_in,
  input  logic [1:0]   Q_LSB,
  output logic [N-1:0] op_A,
  output logic [N-1:0] op_B,
  output logic         dp_rst,
  output logic [4:0]   mult_control,
  output logic         busy,
  output logic         done
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_EVAL  = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  op_a_q, op_a_d;
  logic [N-1:0]  op_b_q, op_b_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic load_a_s;
  logic load_b_s;
  logic load_add_s;
  logic shift_s;
  logic add_sub_s;
  logic dp_rst_s;
  logic busy_s;
  logic done_s;

  // State, captured operands and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= {N{1'b0}};
      op_b_q  <= {N{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and control decode.
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cnt_d      = cnt_q;
    load_a_s   = 1'b0;
    load_b_s   = 1'b0;
    load_add_s = 1'b0;
    shift_s    = 1'b0;
    add_sub_s  = 1'b0;
    dp_rst_s   = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d  = A_in;
          op_b_d  = B_in;
          cnt_d   = {CW{1'b0}};
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        dp_rst_s = 1'b1;
        busy_s   = 1'b1;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        load_a_s = 1'b1;
        load_b_s = 1'b1;
        busy_s   = 1'b1;
        state_d  = S_EVAL;
      end
      S_EVAL: begin
        busy_s  = 1'b1;
        state_d = S_SHIFT;
        // Booth recoding: 01 ends a run of ones (add), 10 starts one (subtract).
        case (Q_LSB)
          2'b01: begin
            load_add_s = 1'b1;
            add_sub_s  = 1'b1;
          end
          2'b10: begin
            load_add_s = 1'b1;
            add_sub_s  = 1'b0;
          end
          default: begin
            load_add_s = 1'b0;
            add_sub_s  = 1'b0;
          end
        endcase
      end
      S_SHIFT: begin
        shift_s = 1'b1;
        busy_s  = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_EVAL;
        end
      end
      S_DONE: begin
        done_s = 1'b1;
        // A start here chains straight into the next operation with no IDLE gap.
        if (start) begin
          op_a_d  = A_in;
          op_b_d  = B_in;
          cnt_d   = {CW{1'b0}};
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign op_A         = op_a_q;
  assign op_B         = op_b_q;
  assign dp_rst       = dp_rst_s;
  assign mult_control = {load_a_s, load_b_s, load_add_s, shift_s, add_sub_s};
  assign busy         = busy_s;
  assign done         = done_s;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb_booth_mult_ctrl: directed bench for booth_mult_ctrl with N=8.
// Contains a behavioural Booth datapath (N+1-bit accumulator so that
// -128 x -128 is exact) driven by the controller's outputs.
module tb_booth_mult_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  A_in;
  logic [7:0]  B_in;
  logic [1:0]  Q_LSB;
  logic [7:0]  op_A;
  logic [7:0]  op_B;
  logic        dp_rst;
  logic [4:0]  mult_control;
  logic        busy;
  logic        done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  booth_mult_ctrl #(.N(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .A_in         (A_in),
    .B_in         (B_in),
    .Q_LSB        (Q_LSB),
    .op_A         (op_A),
    .op_B         (op_B),
    .dp_rst       (dp_rst),
    .mult_control (mult_control),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: M, HQ (9 bits), LQ, Q_1.
  logic [7:0] m_s;
  logic [8:0] hq_s;
  logic [7:0] lq_s;
  logic       q1_s;
  logic [15:0] y_s;

  always_ff @(posedge clk) begin
    if (rst || dp_rst) begin
      m_s  <= 8'h00;
      hq_s <= 9'h000;
      lq_s <= 8'h00;
      q1_s <= 1'b0;
    end else begin
      if (mult_control[4]) m_s <= op_A;
      if (mult_control[3]) begin
        lq_s <= op_B;
        hq_s <= 9'h000;
        q1_s <= 1'b0;
      end
      if (mult_control[2]) begin
        if (mult_control[0]) hq_s <= hq_s + {m_s[7], m_s};
        else                 hq_s <= hq_s - {m_s[7], m_s};
      end
      if (mult_control[1]) {hq_s, lq_s, q1_s} <= {hq_s[8], hq_s, lq_s};
    end
  end

  assign Q_LSB = {lq_s[0], q1_s};
  assign y_s   = {hq_s[7:0], lq_s};

  function automatic logic [15:0] ref_prod(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [15:0] p;
    p = a * b;
    return p;
  endfunction

  function automatic int booth_adds(input logic [7:0] b);
    int   n;
    logic prev;
    n    = 0;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (b[i] != prev) n++;
      prev = b[i];
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE; cycle 0 is the start cycle. Optionally
  // pulses start with other operands at cycle ign_cyc.
  task automatic op_run(input logic [7:0] a, input logic [7:0] b, input int ign_cyc,
                        input logic [7:0] ia, input logic [7:0] ib,
                        output int done_cyc, output int n_done, output logic [15:0] y_done,
                        output logic [7:0] opa_done, output logic [15:0] y_end,
                        output int busy_err, output int proto_err, output int n_add);
    done_cyc  = -1;
    n_done    = 0;
    y_done    = 16'h0000;
    opa_done  = 8'h00;
    busy_err  = 0;
    proto_err = 0;
    n_add     = 0;
    A_in  = a;
    B_in  = b;
    start = 1'b1;
    step();
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (cyc == ign_cyc) begin
        A_in  = ia;
        B_in  = ib;
        start = 1'b1;
      end else begin
        start = 1'b0;
        if (cyc == 1) begin
          A_in = ~a;
          B_in = ~b;
        end
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          y_done   = y_s;
          opa_done = op_A;
        end
      end
      if (busy !== ((cyc >= 1) && (cyc <= 18))) busy_err++;
      if (mult_control[2] && mult_control[1]) proto_err++;
      if (mult_control[0] && !mult_control[2]) proto_err++;
      if (mult_control[2]) n_add++;
      y_end = y_s;
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    A_in  = 8'h12;
    B_in  = 8'h34;
    step();
    step();
    chk_cnt++;
    if ({op_A, op_B} !== 16'h0000) $display("FAIL reset_ops: got %h expected 0000", {op_A, op_B});
    else pass_cnt++;
    chk_cnt++;
    if ({dp_rst, mult_control, busy, done} !== 8'h00)
      $display("FAIL reset_ctrl: got %b expected 00000000", {dp_rst, mult_control, busy, done});
    else pass_cnt++;
    start = 1'b0;
    rst   = 1'b0;
    step();
    chk_cnt++;
    if ({dp_rst, mult_control, busy, done} !== 8'h00)
      $display("FAIL idle_ctrl: got %b expected 00000000", {dp_rst, mult_control, busy, done});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic dp1, busy0;
    logic [4:0] mc2;
    int dcyc, nd;
    A_in  = 8'd3;
    B_in  = 8'd5;
    start = 1'b1;
    busy0 = busy;
    step();
    start = 1'b0;
    dp1 = dp_rst;
    step();
    mc2 = mult_control;
    chk_cnt++;
    if (busy0 !== 1'b0) $display("FAIL busy_c0: got %b expected 0", busy0);
    else pass_cnt++;
    chk_cnt++;
    if (dp1 !== 1'b1) $display("FAIL clear_c1: got %b expected 1", dp1);
    else pass_cnt++;
    chk_cnt++;
    if (mc2 !== 5'b11000) $display("FAIL load_c2: got %b expected 11000", mc2);
    else pass_cnt++;
    dcyc = -1;
    nd   = 0;
    for (int cyc = 2; cyc <= 24; cyc++) begin
      if (done) begin
        nd++;
        dcyc = cyc;
        chk_cnt++;
        if (y_s !== 16'h000F) $display("FAIL basic_y: got %h expected 000f", y_s);
        else pass_cnt++;
      end
      step();
    end
    chk_cnt++;
    if (dcyc !== 19 || nd !== 1) $display("FAIL basic_done: got cycle %0d count %0d expected 19/1", dcyc, nd);
    else pass_cnt++;
  endtask

  task automatic test_products();
    logic [7:0]  va[4] = '{8'd3, 8'hFD, 8'h80, 8'h80};
    logic [7:0]  vb[4] = '{8'd5, 8'd7, 8'h80, 8'd1};
    logic [15:0] ve[4] = '{16'h000F, 16'hFFEB, 16'h4000, 16'hFF80};
    int dc, nd, be, pe, na;
    logic [15:0] yd, ye;
    logic [7:0]  oa;
    for (int i = 0; i < 4; i++) begin
      op_run(va[i], vb[i], -1, 8'h00, 8'h00, dc, nd, yd, oa, ye, be, pe, na);
      chk_cnt++;
      if (yd !== ve[i]) $display("FAIL prod_%0d: got %h expected %h", i, yd, ve[i]);
      else pass_cnt++;
      chk_cnt++;
      if (dc !== 19 || nd !== 1 || be !== 0)
        $display("FAIL timing_%0d: got done %0d count %0d busy_err %0d expected 19/1/0", i, dc, nd, be);
      else pass_cnt++;
      chk_cnt++;
      if (ye !== ve[i]) $display("FAIL y_hold_%0d: got %h expected %h", i, ye, ve[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a1, b1, a2, b2;
    logic [15:0] y1, y2;
    logic        dp20;
    int d1, d2, nd;
    a1 = 8'($urandom); b1 = 8'($urandom);
    a2 = 8'($urandom); b2 = 8'($urandom);
    d1 = -1; d2 = -1; nd = 0; dp20 = 1'b0;
    y1 = 16'h0000; y2 = 16'h0000;
    A_in = a1; B_in = b1; start = 1'b1;
    step();
    for (int cyc = 1; cyc <= 44; cyc++) begin
      if (cyc == 19) begin
        A_in = a2; B_in = b2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        nd++;
        if (d1 < 0) begin
          d1 = cyc; y1 = y_s;
        end else if (d2 < 0) begin
          d2 = cyc; y2 = y_s;
        end
      end
      if (cyc == 20) dp20 = dp_rst;
      step();
    end
    start = 1'b0;
    chk_cnt++;
    if (d1 !== 19 || d2 !== 38 || nd !== 2)
      $display("FAIL b2b_done: got %0d/%0d count %0d expected 19/38/2", d1, d2, nd);
    else pass_cnt++;
    chk_cnt++;
    if (dp20 !== 1'b1) $display("FAIL b2b_gap: got dp_rst %b expected 1", dp20);
    else pass_cnt++;
    chk_cnt++;
    if (y1 !== ref_prod(a1, b1)) $display("FAIL b2b_y1: got %h expected %h", y1, ref_prod(a1, b1));
    else pass_cnt++;
    chk_cnt++;
    if (y2 !== ref_prod(a2, b2)) $display("FAIL b2b_y2: got %h expected %h", y2, ref_prod(a2, b2));
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int dc, nd, be, pe, na;
    logic [15:0] yd, ye;
    logic [7:0]  oa;
    op_run(8'd3, 8'd5, 6, 8'd9, 8'd11, dc, nd, yd, oa, ye, be, pe, na);
    chk_cnt++;
    if (yd !== 16'h000F || oa !== 8'd3) $display("FAIL ignore_y: got %h op_A %h expected 000f/03", yd, oa);
    else pass_cnt++;
    chk_cnt++;
    if (nd !== 1 || dc !== 19) $display("FAIL ignore_done: got count %0d cycle %0d expected 1/19", nd, dc);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int dc, nd, be, pe, na, late;
    logic [15:0] yd, ye;
    logic [7:0]  oa;
    A_in = 8'd3; B_in = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt++;
    if ({dp_rst, mult_control, busy, done} !== 8'h00)
      $display("FAIL abort_ctrl: got %b expected 00000000", {dp_rst, mult_control, busy, done});
    else pass_cnt++;
    chk_cnt++;
    if ({op_A, op_B} !== 16'h0000) $display("FAIL abort_ops: got %h expected 0000", {op_A, op_B});
    else pass_cnt++;
    late = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (done || busy) late++;
      step();
    end
    chk_cnt++;
    if (late !== 0) $display("FAIL abort_nodone: got %0d active cycles expected 0", late);
    else pass_cnt++;
    op_run(8'd2, 8'hFE, -1, 8'h00, 8'h00, dc, nd, yd, oa, ye, be, pe, na);
    chk_cnt++;
    if (yd !== 16'hFFFC || dc !== 19) $display("FAIL abort_fresh: got %h cycle %0d expected fffc/19", yd, dc);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int dc, nd, be, pe, na;
    int y_err, t_err, p_err, a_err;
    logic [15:0] yd, ye;
    logic [7:0]  oa, a, b;
    y_err = 0; t_err = 0; p_err = 0; a_err = 0;
    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      op_run(a, b, -1, 8'h00, 8'h00, dc, nd, yd, oa, ye, be, pe, na);
      if (yd !== ref_prod(a, b) || ye !== yd) y_err++;
      if (dc !== 19 || nd !== 1 || be !== 0) t_err++;
      if (pe !== 0) p_err++;
      if (na !== booth_adds(b)) a_err++;
    end
    chk_cnt++;
    if (y_err !== 0) $display("FAIL rand_prod: got %0d bad ops expected 0", y_err);
    else pass_cnt++;
    chk_cnt++;
    if (t_err !== 0) $display("FAIL rand_timing: got %0d bad ops expected 0", t_err);
    else pass_cnt++;
    chk_cnt++;
    if (p_err !== 0) $display("FAIL rand_protocol: got %0d bad ops expected 0", p_err);
    else pass_cnt++;
    chk_cnt++;
    if (a_err !== 0) $display("FAIL rand_booth_adds: got %0d bad ops expected 0", a_err);
    else pass_cnt++;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A_in  = 8'h00;
    B_in  = 8'h00;
    #1;
    test_reset();
    test_basic();
    test_products();
    test_back_to_back();
    test_ignore_start();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
